// File: rtl/flappy_bird_physics_if.sv
// flappy_bird_physics_if: control inputs and bird-state outputs of the physics engine.
interface flappy_bird_physics_if #(
    parameter int W  = 10,
    parameter int VW = 8
);
    logic          Start;
    logic          Ack;
    logic          Flap_Button;
    logic [W-1:0]  YBird;
    logic [W-1:0]  XBird;
    logic [VW-1:0] Velocity;
    logic          Tick;
    logic          q_I;
    logic          q_Fly;
    logic          q_Lost;

    modport master (
        output Start, Ack, Flap_Button,
        input  YBird, XBird, Velocity, Tick, q_I, q_Fly, q_Lost
    );

    modport slave (
        input  Start, Ack, Flap_Button,
        output YBird, XBird, Velocity, Tick, q_I, q_Fly, q_Lost
    );
endinterface

// File: rtl/flappy_bird_physics.sv
// flappy_bird_physics: ticked gravity/flap integration with ceiling clamp and floor loss.
module flappy_bird_physics #(
    parameter int W        = 10,
    parameter int VW       = 8,
    parameter int TICK_DIV = 500000,
    parameter int X_START  = 100,
    parameter int Y_START  = 240,
    parameter int Y_TOP    = 0,
    parameter int Y_FLOOR  = 460,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 8,
    parameter int VMAX     = 12
) (
    input logic Clk,
    input logic Reset,
    flappy_bird_physics_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic signed [VW:0]  VMAX_S  = (VW+1)'(VMAX);
    localparam logic signed [VW:0]  FLAP_S  = (VW+1)'(-FLAP_VEL);
    localparam logic signed [VW:0]  GRAV_S  = (VW+1)'(GRAVITY);
    localparam logic signed [W+1:0] Y_TOP_S = (W+2)'(Y_TOP);
    localparam logic signed [W+1:0] Y_FLR_S = (W+2)'(Y_FLOOR);

    typedef enum logic [1:0] {IDLE, FLY, LOST} state_t;
    state_t state;

    logic [CW-1:0]    cnt;
    logic             flap_q, flap_pend, flap_evt, tick_now;
    logic signed [VW:0]  v_grav, v_next;
    logic signed [W+1:0] y_next;

    assign flap_evt = bus.Flap_Button & ~flap_q;
    assign tick_now = (state == FLY) && (cnt == CW'(TICK_DIV - 1));

    // Extra bit on the velocity sum keeps VMAX+GRAVITY from wrapping before the clamp
    always_comb begin
        v_grav = $signed({bus.Velocity[VW-1], bus.Velocity}) + GRAV_S;
        v_next = (flap_pend | flap_evt) ? FLAP_S : (v_grav > VMAX_S ? VMAX_S : v_grav);
        y_next = $signed({2'b00, bus.YBird}) + $signed({{(W+1-VW){v_next[VW]}}, v_next});
    end

    assign bus.XBird  = W'(X_START);
    assign bus.q_I    = (state == IDLE);
    assign bus.q_Fly  = (state == FLY);
    assign bus.q_Lost = (state == LOST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            bus.YBird    <= W'(Y_START);
            bus.Velocity <= '0;
            bus.Tick     <= 1'b0;
            cnt          <= '0;
            flap_q       <= 1'b0;
            flap_pend    <= 1'b0;
        end else begin
            flap_q   <= bus.Flap_Button;
            bus.Tick <= tick_now;
            unique case (state)
                IDLE: begin
                    bus.YBird    <= W'(Y_START);
                    bus.Velocity <= '0;
                    cnt          <= '0;
                    flap_pend    <= 1'b0;
                    if (bus.Start) state <= FLY;
                end
                FLY: begin
                    cnt <= tick_now ? '0 : cnt + 1'b1;
                    if (tick_now) begin
                        flap_pend <= 1'b0;
                        if (y_next <= Y_TOP_S) begin
                            bus.YBird    <= W'(Y_TOP);
                            bus.Velocity <= '0;
                        end else if (y_next >= Y_FLR_S) begin
                            bus.YBird    <= W'(Y_FLOOR);
                            bus.Velocity <= '0;
                            state        <= LOST;
                        end else begin
                            bus.YBird    <= y_next[W-1:0];
                            bus.Velocity <= v_next[VW-1:0];
                        end
                    end else if (flap_evt) begin
                        flap_pend <= 1'b1;
                    end
                end
                LOST: begin
                    cnt       <= '0;
                    flap_pend <= 1'b0;
                    if (bus.Ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flappy_bird_physics.sv
// tb_flappy_bird_physics: directed checks of flight, flap, clamps, loss and reset.
module tb_flappy_bird_physics;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    flappy_bird_physics_if #(.W(10), .VW(8)) bus();
    flappy_bird_physics #(.TICK_DIV(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!bus.Tick && cycles < 10);
        if (!bus.Tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.Start = 1'b0;
        bus.Ack = 1'b0;
        bus.Flap_Button = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic start_flight();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    initial begin
        int c, k, v, y, yn;
        bus.Start = 1'b0;
        bus.Ack = 1'b0;
        bus.Flap_Button = 1'b0;

        // 1: reset state and free-fall velocity ramp
        do_reset();
        chk("rst_qi", bus.q_I, 1);
        chk("rst_y", bus.YBird, 240);
        chk("rst_x", bus.XBird, 100);
        chk("rst_v", $signed(bus.Velocity), 0);
        chk("rst_tick", bus.Tick, 0);
        start_flight();
        chk("fly_state", bus.q_Fly, 1);
        chk("fly_y0", bus.YBird, 240);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_early_tick", bus.Tick, 0);
        end
        step();
        chk("first_tick", bus.Tick, 1);
        chk("first_v", $signed(bus.Velocity), 1);
        chk("first_y", bus.YBird, 241);
        y = 241;
        v = 1;
        k = 1;
        for (int i = 0; i < 30; i++) begin
            wait_tick(c);
            k++;
            chk("tick_period", c, 4);
            v = (v + 1 > 12) ? 12 : v + 1;
            yn = y + v;
            if (yn >= 460) begin
                chk("floor_y", bus.YBird, 460);
                chk("floor_v", $signed(bus.Velocity), 0);
                chk("floor_lost", bus.q_Lost, 1);
                break;
            end
            y = yn;
            chk("fall_y", bus.YBird, y);
            chk("fall_v", $signed(bus.Velocity), v);
            if (k == 4) chk("fall_y_k4", bus.YBird, 250);
        end
        chk("loss_tick_index", k, 24);

        // 2: LOST freezes everything, ignores Start/flaps; Ack with Start goes to IDLE only
        bus.Start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.Flap_Button = i[1];
            step();
            chk("lost_y", bus.YBird, 460);
            chk("lost_v", $signed(bus.Velocity), 0);
            chk("lost_q", bus.q_Lost, 1);
            chk("lost_tick", bus.Tick, 0);
        end
        bus.Flap_Button = 1'b0;
        bus.Ack = 1'b1;
        step();
        bus.Ack = 1'b0;
        bus.Start = 1'b0;
        chk("ack_qi", bus.q_I, 1);
        chk("ack_qfly", bus.q_Fly, 0);
        step();
        chk("idle_y", bus.YBird, 240);
        chk("idle_v", $signed(bus.Velocity), 0);
        chk("idle_stays", bus.q_I, 1);

        // 3: held flap gives a single impulse
        do_reset();
        start_flight();
        for (int i = 0; i < 3; i++) wait_tick(c);
        chk("pre_flap_y", bus.YBird, 246);
        chk("pre_flap_v", $signed(bus.Velocity), 3);
        bus.Flap_Button = 1'b1;
        y = 246;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.Tick) begin
                k++;
                v = (k == 1) ? -8 : v + 1;
                y = y + v;
                chk("held_v", $signed(bus.Velocity), v);
                chk("held_y", bus.YBird, y);
            end
        end
        chk("held_ticks", k, 10);
        chk("held_last_y", bus.YBird, 211);
        bus.Flap_Button = 1'b0;

        // 4: flap every tick climbs to the ceiling; exact 0 clamps with velocity 0
        do_reset();
        start_flight();
        for (int t = 1; t <= 30; t++) begin
            bus.Flap_Button = 1'b1;
            step();
            bus.Flap_Button = 1'b0;
            wait_tick(c);
            chk("climb_y", bus.YBird, t == 30 ? 0 : 240 - 8 * t);
            chk("climb_v", $signed(bus.Velocity), t == 30 ? 0 : -8);
        end
        chk("ceiling_fly", bus.q_Fly, 1);
        wait_tick(c);
        chk("after_ceiling_v", $signed(bus.Velocity), 1);
        chk("after_ceiling_y", bus.YBird, 1);

        // 5: flap rising on the tick edge is consumed by that tick
        do_reset();
        start_flight();
        wait_tick(c);
        chk("t5_y", bus.YBird, 241);
        for (int i = 0; i < 3; i++) step();
        chk("t5_pre_tick", bus.Tick, 0);
        bus.Flap_Button = 1'b1;
        step();
        chk("t5_tick", bus.Tick, 1);
        chk("t5_v", $signed(bus.Velocity), -8);
        chk("t5_y_up", bus.YBird, 233);
        wait_tick(c);
        chk("t5_next_v", $signed(bus.Velocity), -7);
        chk("t5_next_y", bus.YBird, 226);
        bus.Flap_Button = 1'b0;

        // 6: reset mid-flight on what would be a tick edge
        do_reset();
        start_flight();
        for (int i = 0; i < 10; i++) wait_tick(c);
        chk("t6_y", bus.YBird, 295);
        for (int i = 0; i < 3; i++) step();
        Reset = 1'b1;
        step();
        chk("t6_qi", bus.q_I, 1);
        chk("t6_qfly", bus.q_Fly, 0);
        chk("t6_y_rst", bus.YBird, 240);
        chk("t6_v_rst", $signed(bus.Velocity), 0);
        chk("t6_tick", bus.Tick, 0);
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
